// File: rtl/fp_normalizer.sv
// Sequential post-add normalizer: shifts the extended mantissa one bit per cycle
// until the hidden bit is set, with carry, zero, underflow and overflow handling.
module fp_normalizer #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] exp,
  input  logic [MAN_W-1:0] mantis,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] exp_out,
  output logic [MAN_W-1:0] mantis_out,
  output logic [7:0]       shift_number,
  output logic             zero,
  output logic             underflow,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_SAT = EXP_MAX - 1'b1;
  localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [MAN_W-1:0] man_q, man_d;
  logic [7:0]       shift_q, shift_d;
  logic             zero_q, zero_d;
  logic             uf_q, uf_d;
  logic             of_q, of_d;

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    man_d   = man_q;
    shift_d = shift_q;
    zero_d  = zero_q;
    uf_d    = uf_q;
    of_d    = of_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          exp_d   = exp;
          man_d   = mantis;
          shift_d = 8'd0;
          zero_d  = 1'b0;
          uf_d    = 1'b0;
          of_d    = 1'b0;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (man_q == '0) begin
          exp_d   = '0;
          zero_d  = 1'b1;
          state_d = DONE;
        end else if (man_q[MAN_W-1]) begin
          // Carry-out: one right shift, folding the dropped bit into sticky
          man_d   = {1'b0, man_q[MAN_W-1:2], man_q[1] | man_q[0]};
          shift_d = 8'hFF;
          if (exp_q >= EXP_SAT) begin
            exp_d = EXP_MAX;
            man_d = '0;
            of_d  = 1'b1;
          end else begin
            exp_d = exp_q + EXP_ONE;
          end
          state_d = DONE;
        end else if (man_q[MAN_W-2]) begin
          state_d = DONE;
        end else if (exp_q == '0) begin
          uf_d    = 1'b1;
          state_d = DONE;
        end else begin
          man_d   = {man_q[MAN_W-2:0], 1'b0};
          exp_d   = exp_q - EXP_ONE;
          shift_d = shift_q + 8'd1;
          state_d = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      exp_q   <= '0;
      man_q   <= '0;
      shift_q <= 8'd0;
      zero_q  <= 1'b0;
      uf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      man_q   <= man_d;
      shift_q <= shift_d;
      zero_q  <= zero_d;
      uf_q    <= uf_d;
      of_q    <= of_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign exp_out      = exp_q;
  assign mantis_out   = man_q;
  assign shift_number = shift_q;
  assign zero         = zero_q;
  assign underflow    = uf_q;
  assign overflow     = of_q;

endmodule
